// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep unit: mode encodings, FSM state type
// and the maximum supported gate input count.
package gate_sweep_pkg;

  localparam int unsigned N_IN_MAX = 6;
  localparam int unsigned MODE_W   = 3;

  localparam logic [MODE_W-1:0] MODE_AND  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_OR   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_NAND = 3'd2;
  localparam logic [MODE_W-1:0] MODE_NOR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_XOR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Encodings above MODE_XNOR are reserved.
  function automatic logic mode_is_legal(input logic [MODE_W-1:0] m);
    return (m <= MODE_XNOR);
  endfunction

endpackage

// File: rtl/gate_sweep_unit_gate.sv
// multi_input_gate: combinational N_IN-input gate selected by mode.
// Ports:
//   vec  - gate inputs (N_IN bits)
//   mode - gate function (AND/OR/NAND/NOR/XOR/XNOR, reserved -> 0)
//   y    - gate output
module multi_input_gate
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 3
) (
  input  logic [N_IN-1:0]   vec,
  input  logic [MODE_W-1:0] mode,
  output logic              y
);

  // XOR/XNOR are full parity / inverted parity over all inputs.
  always_comb begin
    y = 1'b0;
    case (mode)
      MODE_AND:  y = &vec;
      MODE_OR:   y = |vec;
      MODE_NAND: y = ~&vec;
      MODE_NOR:  y = ~|vec;
      MODE_XOR:  y = ^vec;
      MODE_XNOR: y = ~^vec;
      default:   y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_unit.sv
// gate_sweep_unit: sweeps every input vector through a multi-input gate and
// captures the resulting truth table and count of ones.
// Optional feature macro: SWEEP_HOLD_EN (hold each vector HOLD_CYC cycles).
// Ports:
//   clk, rst_n - clock (rising edge), asynchronous active-low reset
//   start      - single-cycle sweep request (accepted only in IDLE)
//   mode       - gate function, latched at start
//   busy       - high while sweeping (SWEEP or DONE)
//   vec        - vector currently applied to the gate
//   out        - registered gate result, qualified by out_valid
//   out_valid  - one pulse per vector
//   tt         - captured truth table, tt[i] = result of vector i
//   ones_cnt   - number of results equal to 1
//   done       - pulse with the last out_valid
//   err        - pulse one cycle after start with a reserved mode
module gate_sweep_unit
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN     = 3,
  parameter int unsigned HOLD_CYC = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [MODE_W-1:0]      mode,
  output logic                   busy,
  output logic [N_IN-1:0]        vec,
  output logic                   out,
  output logic                   out_valid,
  output logic [(2**N_IN)-1:0]   tt,
  output logic [N_IN:0]          ones_cnt,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned TT_W  = 2**N_IN;
  localparam int unsigned CNT_W = N_IN + 1;
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  if (N_IN < 2 || N_IN > N_IN_MAX || HOLD_CYC < 1) begin : g_param_err
    $error("gate_sweep_unit: illegal N_IN or HOLD_CYC");
  end

  state_t              state_q, state_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [N_IN-1:0]     vec_d;
  logic                out_d, out_valid_d;
  logic [TT_W-1:0]     tt_d;
  logic [CNT_W-1:0]    ones_d;
  logic                done_d, err_d, busy_d;
  logic                gate_y;
  logic                step_c;

  multi_input_gate #(.N_IN(N_IN)) u_gate (
    .vec  (vec),
    .mode (mode_q),
    .y    (gate_y)
  );

`ifdef SWEEP_HOLD_EN
  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Advance to the next vector on the last hold cycle.
  assign step_c = (hold_q == HOLD_W'(HOLD_CYC - 1));

  // Hold counter runs only while sweeping; zero everywhere else.
  always_comb begin
    hold_d = '0;
    if (state_q == ST_SWEEP && !step_c) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign step_c = 1'b1;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    vec_d       = vec;
    out_d       = out;
    out_valid_d = 1'b0;
    tt_d        = tt;
    ones_d      = ones_cnt;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // Capture the previous cycle's result into the truth table.
    if (out_valid) begin
      tt_d[idx_q] = out;
      ones_d      = ones_cnt + CNT_W'(out);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mode_is_legal(mode)) begin
            state_d = ST_SWEEP;
            mode_d  = mode;
            vec_d   = '0;
            tt_d    = '0;
            ones_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SWEEP: begin
        if (step_c) begin
          out_d       = gate_y;
          out_valid_d = 1'b1;
          idx_d       = vec;
          if (vec == VEC_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            vec_d = vec + N_IN'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      idx_q     <= '0;
      vec       <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      tt        <= '0;
      ones_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      vec       <= vec_d;
      out       <= out_d;
      out_valid <= out_valid_d;
      tt        <= tt_d;
      ones_cnt  <= ones_d;
      done      <= done_d;
      err       <= err_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Scoreboard bench for gate_sweep_unit (N_IN=3).
module tb_gate_sweep_unit;

  localparam int unsigned N_IN = 3;
  localparam int unsigned HOLD = 10;
`ifdef SWEEP_HOLD_EN
  localparam int H = HOLD;
`else
  localparam int H = 1;
`endif
  localparam int LAT = 8 * H + 1;

  typedef struct packed {
    logic [7:0] tt;
    logic [3:0] ones;
  } exp_t;

  logic       clk, rst_n, start;
  logic [2:0] mode;
  logic       busy, out, out_valid, done, err;
  logic [2:0] vec;
  logic [7:0] tt;
  logic [3:0] ones_cnt;

  gate_sweep_unit #(.N_IN(N_IN), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .vec(vec), .out(out), .out_valid(out_valid),
    .tt(tt), .ones_cnt(ones_cnt), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   sc = 0;
  bit   sweep_live = 0;
  bit   pend_final = 0;
  bit   err_ok = 0;
  int   ov_idx = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      ov_idx     = 0;
      pend_final = 0;
      sweep_live = 0;
    end else begin
      if (err && !err_ok) chk("err_spurious", err, 0);
      if (pend_final) begin
        chk("tt_final", tt, sb[0].tt);
        chk("ones_final", ones_cnt, sb[0].ones);
        chk("busy_after_done", busy, 0);
        void'(sb.pop_front());
        pend_final = 0;
      end
      if (sweep_live && cyc >= sc + 1) begin
        int d;
        d = (cyc - sc - 1) / H;
        if (d > 7) d = 7;
        chk("vec_seq", vec, d);
        chk("busy_sweep", busy, 1);
      end
      if (out_valid) begin
        if (sb.size() == 0 || ov_idx > 7) begin
          chk("out_valid_unexpected", out_valid, 0);
        end else begin
          exp_t       e;
          logic [7:0] et;
          e  = sb[0];
          et = e.tt;
          chk("out_bit", out, et[ov_idx]);
          chk("out_valid_cycle", cyc, sc + 1 + H * (ov_idx + 1));
          ov_idx++;
        end
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          chk("done_latency", cyc - sc, LAT);
          chk("done_vec_count", ov_idx, 8);
          pend_final = 1;
        end
        sweep_live = 0;
        ov_idx     = 0;
      end
    end
  end

  task automatic do_start(input logic [2:0] m, input exp_t e);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    sc    = cyc;
    sb.push_back(e);
    sweep_live = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || sweep_live) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("timeout_wait_idle", 1, 0);
      sb.delete();
      sweep_live = 0;
    end
    repeat (2) @(negedge clk);
  endtask

  logic [2:0] modes [6] = '{3'd2, 3'd0, 3'd1, 3'd3, 3'd4, 3'd5};
  logic [7:0] ett   [6] = '{8'h7F, 8'h80, 8'hFE, 8'h01, 8'h96, 8'h69};
  logic [3:0] eones [6] = '{4'd7, 4'd1, 4'd7, 4'd1, 4'd4, 4'd4};

  initial begin
    int n;
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, vec, out, out_valid, tt, ones_cnt, done, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, tt, ones_cnt}, 0);

    // All six gate functions.
    for (int i = 0; i < 6; i++) begin
      do_start(modes[i], '{tt: ett[i], ones: eones[i]});
      wait_idle();
    end
    chk("tt_hold_idle", tt, 8'h69);
    chk("vec_hold_idle", vec, 3'd7);

    // Reserved modes are rejected.
    for (int m = 6; m < 8; m++) begin
      @(negedge clk);
      err_ok = 1;
      start  = 1'b1;
      mode   = 3'(m);
      @(negedge clk);
      start  = 1'b0;
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      @(negedge clk);
      chk("err_single", err, 0);
      chk("err_busy2", busy, 0);
      chk("err_tt_kept", tt, 8'h69);
      chk("err_ones_kept", ones_cnt, 4'd4);
      err_ok = 0;
    end

    // Start re-pulsed mid-sweep with another mode is ignored.
    d0 = done_cnt;
    do_start(3'd2, '{tt: 8'h7F, ones: 4'd7});
    repeat (2) @(negedge clk);
    start = 1'b1;
    mode  = 3'd0;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("restart_one_done", done_cnt - d0, 1);

    // Asynchronous reset in the middle of a sweep.
    d0 = done_cnt;
    do_start(3'd2, '{tt: 8'h7F, ones: 4'd7});
    n = 0;
    while (vec != 3'd5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("timeout_vec5", 1, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, vec, out, out_valid, done, err}, 0);
    chk("abort_tt", tt, 0);
    chk("abort_ones", ones_cnt, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", {done, busy}, 0);
    end
    rst_n = 1'b1;
    start = 1'b1;
    mode  = 3'd4;
    #1;
    sc = cyc;
    sb.push_back('{tt: 8'h96, ones: 4'd4});
    sweep_live = 1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("abort_then_one_done", done_cnt - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
